trap_ctrl_v2: RTL and testbench
===============================

Name: trap_ctrl_v2

Overview:
- Parametrised machine-mode trap controller between the ID/EX stage and the CSR file of the RISC-V core.
- Arbitrates synchronous exceptions against standard and NUM_LOCAL_INT local interrupts (mip/mie bits 16+).
- Holds an accepted interrupt in a registered ARMED state until an instruction boundary, then produces mepc, mcause and the trap target.
- Supports direct and vectored mtvec, an optional external-controller cause redirect, and a configurable jump-tracking window for mepc.

Parameters:
- PC_LEN, 32, width of instruction addresses.
- NUM_LOCAL_INT, 8, local interrupt count (1..16), at mie/mip bits 16..16+NUM_LOCAL_INT-1.
- EXC_CODE_W, 5, width of the synchronous exception code.
- JUMP_HOLD, 2, cycles a taken jump target overrides the ID/EX address for mepc (1..7).
- EXT_REDIRECT, 1, if 1, the MEI cause is {ext_int_code,4'b0}; if 0, the cause is 11.

Ports:
- clk  in  1  core clock
- rst_sync  in  1  synchronous active-high reset
- flush  in  1  pipeline flush
- stall_n  in  1  0 = pipeline stalled; no state advances
- exc_raise  in  1  synchronous exception at the commit point
- exc_code  in  EXC_CODE_W  exception code
- instr_addr_id_ex  in  PC_LEN  address of the instruction in ID/EX
- jump_addr_ex  in  PC_LEN  taken jump target
- jump_en_ex  in  1  jump taken in EX
- mstatus_mie  in  1  global interrupt enable
- mie  in  16+NUM_LOCAL_INT  interrupt enables
- mip  in  16+NUM_LOCAL_INT  interrupt pending bits
- mtvec_base  in  30  mtvec.BASE
- mtvec_mode  in  2  mtvec.MODE
- ext_int_code  in  27  external interrupt controller source code
- any_interrupt_come  out  1  (mie&mip)!=0, combinational
- valid_interrupt_request  out  1  interrupt eligible; the core flushes on this
- trap_occurred  out  1  trap commit pulse
- trap_busy  out  1  FSM not IDLE
- new_mepc  out  PC_LEN  mepc write value
- new_mcause  out  32  mcause write value
- trap_jump_addr  out  32  trap target PC

Behaviour:
- All registers reset by rst_sync at the clock edge. Reset values: state=IDLE, latched cause=0, jump counter=0, last_jump_addr=0.
- Reset forces trap_occurred=0 and trap_busy=0, including a reset asserted mid-ARMED.
- Interrupt priority, highest first: MEI(11), MSI(3), MTI(7), then local 16..(15+NUM_LOCAL_INT), lower index higher. Only bits with mie&mip set compete. All other bits are ignored.
- valid_interrupt_request = any_interrupt_come & mstatus_mie & !exc_raise & state==IDLE.
- FSM states IDLE, ARMED, TRAP.
- IDLE->ARMED when valid_interrupt_request & stall_n & !flush. The winning cause code is latched on this transition.
- ARMED->TRAP on the next cycle with stall_n=1.
- ARMED->IDLE with no trap if the latched source is no longer mie&mip, or mstatus_mie=0, when stall_n=1.
- ARMED->IDLE with no interrupt trap if exc_raise=1. The exception is taken instead and the interrupt is re-evaluated afterwards.
- TRAP->IDLE unconditionally after one cycle.
- While stall_n=0 the state holds, and so do the jump counter and last_jump_addr.
- trap_occurred = (state==TRAP) | exc_raise.
- Exception path is combinational:
  - mcause = {1'b0, zero-extended exc_code}.
  - Target = {mtvec_base,2'b00} for every mtvec_mode.
- Interrupt path (state==TRAP):
  - mcause = {1'b1, latched 31-bit code}.
  - Target = {mtvec_base + code[29:0], 2'b00} if mtvec_mode==2'b01. The addition is mod 2^30.
  - Otherwise target = {mtvec_base,2'b00}.
- Jump tracking, when stall_n=1:
  - jump_en_ex loads last_jump_addr and sets the counter to JUMP_HOLD.
  - Otherwise the counter decrements, saturating at 0.
  - trap_occurred clears the counter.
- new_mepc = (counter!=0) ? last_jump_addr : instr_addr_id_ex.
- A simultaneous jump_en_ex and trap_occurred still yields the pre-update mepc. The clear has priority over the load.
- flush does not abort ARMED or TRAP. flush only blocks a new IDLE->ARMED.

Test Plan:
- Reset, then idle inputs -> all outputs 0, trap_busy=0, new_mepc=instr_addr_id_ex.
- mstatus_mie=1, mie=mip=0x80 (MTI), mtvec=0x0000_1001 -> ARMED next cycle, then trap_occurred for 1 cycle, mcause=0x8000_0007, trap_jump_addr=0x0000_101C.
- MEI+MSI+local16 all pending, EXT_REDIRECT=1, ext_int_code=5 -> mcause=0x8000_0050. With EXT_REDIRECT=0 -> mcause=0x8000_000B.
- exc_raise=1, exc_code=2 while ARMED -> same-cycle trap_occurred, mcause=0x0000_0002, target=base, FSM returns to IDLE.
- jump_en_ex at 0x200, JUMP_HOLD=2 -> new_mepc=0x200 for 2 unstalled cycles; stall_n=0 holds it; cycle 3 shows instr_addr_id_ex.
- mip drops while ARMED -> no trap_occurred, FSM returns to IDLE. rst_sync asserted in ARMED -> IDLE, no trap.

Source files
------------

// File: rtl/trap_ctrl_v2.sv
// ---------------------------------------------------------------------------
// trap_ctrl_v2
//
// Machine-mode trap controller between the ID/EX stage and the CSR file.
// It arbitrates synchronous exceptions against the standard machine
// interrupts (MEI, MSI, MTI) and NUM_LOCAL_INT local interrupts that live at
// mie/mip bits 16 and up.
//
// An accepted interrupt is parked in a registered ARMED state until the
// pipeline reaches an instruction boundary. It is then committed in TRAP,
// which produces mepc, mcause and the trap target. Exceptions take a purely
// combinational path and commit in the same cycle that they are raised.
//
// Ports:
//   clk                     core clock
//   rst_sync                synchronous active-high reset
//   flush                   pipeline flush (only blocks a new IDLE->ARMED)
//   stall_n                 0 = pipeline stalled, FSM and jump tracker hold
//   exc_raise / exc_code    synchronous exception at the commit point
//   instr_addr_id_ex        address of the instruction in ID/EX
//   jump_addr_ex/jump_en_ex taken jump target and its valid strobe
//   mstatus_mie, mie, mip   global enable, per-source enables and pendings
//   mtvec_base/mtvec_mode   mtvec fields
//   ext_int_code            external interrupt controller source code
//   any_interrupt_come      (mie & mip) != 0
//   valid_interrupt_request interrupt eligible, the core flushes on this
//   trap_occurred           trap commit pulse (CSR write strobe)
//   trap_busy               FSM not IDLE
//   new_mepc/new_mcause     CSR write values
//   trap_jump_addr          trap target PC
// ---------------------------------------------------------------------------
module trap_ctrl_v2 #(
  parameter int PC_LEN        = 32,
  parameter int NUM_LOCAL_INT = 8,
  parameter int EXC_CODE_W    = 5,
  parameter int JUMP_HOLD     = 2,
  parameter int EXT_REDIRECT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_sync,
  input  logic                      flush,
  input  logic                      stall_n,
  input  logic                      exc_raise,
  input  logic [EXC_CODE_W-1:0]     exc_code,
  input  logic [PC_LEN-1:0]         instr_addr_id_ex,
  input  logic [PC_LEN-1:0]         jump_addr_ex,
  input  logic                      jump_en_ex,
  input  logic                      mstatus_mie,
  input  logic [16+NUM_LOCAL_INT-1:0] mie,
  input  logic [16+NUM_LOCAL_INT-1:0] mip,
  input  logic [29:0]               mtvec_base,
  input  logic [1:0]                mtvec_mode,
  input  logic [26:0]               ext_int_code,
  output logic                      any_interrupt_come,
  output logic                      valid_interrupt_request,
  output logic                      trap_occurred,
  output logic                      trap_busy,
  output logic [PC_LEN-1:0]         new_mepc,
  output logic [31:0]               new_mcause,
  output logic [31:0]               trap_jump_addr
);

  localparam int IRQ_W = 16 + NUM_LOCAL_INT;
  localparam int IDX_W = 5;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [30:0]        cause_q, cause_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [CNT_W-1:0]   jump_cnt_q;
  logic [PC_LEN-1:0]  last_jump_q;

  logic [IRQ_W-1:0]   pend;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [30:0]        win_code;
  logic               trap_int;

  assign pend               = mie & mip;
  assign any_interrupt_come = |pend;

  assign valid_interrupt_request = any_interrupt_come & mstatus_mie & ~exc_raise &
                                   (state_q == IDLE);

  // Fixed-priority pick among enabled+pending sources: MEI, MSI, MTI, then
  // the local lines with the lowest index winning. The local scan runs from
  // the top down so the last hit (lowest index) is the one that sticks.
  // Pending bits outside these sources never produce a winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (pend[11]) begin
      win_found = 1'b1;
      win_idx   = IDX_W'(11);
    end else if (pend[3]) begin
      win_found = 1'b1;
      win_idx   = IDX_W'(3);
    end else if (pend[7]) begin
      win_found = 1'b1;
      win_idx   = IDX_W'(7);
    end else begin
      for (int i = NUM_LOCAL_INT - 1; i >= 0; i--) begin
        if (pend[16+i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(16 + i);
        end
      end
    end
  end

  // Cause code for the winner. An external controller can redirect MEI to
  // its own source code (shifted up by 4) so software can dispatch directly.
  always_comb begin
    win_code = {{(31-IDX_W){1'b0}}, win_idx};
    if ((win_idx == IDX_W'(11)) && (EXT_REDIRECT != 0)) begin
      win_code = {ext_int_code, 4'b0000};
    end
  end

  // Next-state logic. The interrupt source index is kept alongside the cause
  // so ARMED can notice when that particular source is withdrawn. An
  // exception seen while ARMED wins; the interrupt is dropped and simply
  // re-arbitrated once the FSM is back in IDLE. TRAP always lasts exactly
  // one cycle, even under stall, so the commit strobe is a single pulse.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        if (valid_interrupt_request && win_found && stall_n && !flush) begin
          state_d = ARMED;
          cause_d = win_code;
          src_d   = win_idx;
        end
      end
      ARMED: begin
        if (stall_n) begin
          if (exc_raise || !pend[src_q] || !mstatus_mie) begin
            state_d = IDLE;
          end else begin
            state_d = TRAP;
          end
        end
      end
      TRAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and latched cause/source registers.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= IDLE;
      cause_q <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      src_q   <= src_d;
    end
  end

  // Raw trap indication, used internally even in the reset cycle; the
  // outputs are masked by reset so nothing commits while it is asserted.
  assign trap_int      = (state_q == TRAP) | exc_raise;
  assign trap_occurred = trap_int & ~rst_sync;
  assign trap_busy     = (state_q != IDLE) & ~rst_sync;

  // Jump tracker: for JUMP_HOLD unstalled cycles after a taken jump, the
  // instruction in ID/EX is not yet the architectural successor, so mepc
  // must point at the jump target instead. A trap clears the window and
  // wins over a jump arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      jump_cnt_q  <= '0;
      last_jump_q <= '0;
    end else if (stall_n) begin
      if (trap_int) begin
        jump_cnt_q <= '0;
      end else if (jump_en_ex) begin
        jump_cnt_q  <= CNT_W'(JUMP_HOLD);
        last_jump_q <= jump_addr_ex;
      end else if (jump_cnt_q != '0) begin
        jump_cnt_q <= jump_cnt_q - CNT_W'(1);
      end
    end
  end

  assign new_mepc = (jump_cnt_q != '0) ? last_jump_q : instr_addr_id_ex;

  // CSR write values. A committing interrupt takes precedence over a
  // same-cycle exception. Vectored mode offsets the base by the cause code
  // in words, wrapping inside the 30-bit BASE field. Exceptions always
  // jump to the base. With no trap the values are parked at zero.
  always_comb begin
    new_mcause     = '0;
    trap_jump_addr = '0;
    if (state_q == TRAP) begin
      new_mcause = {1'b1, cause_q};
      if (mtvec_mode == 2'b01) begin
        trap_jump_addr = {mtvec_base + cause_q[29:0], 2'b00};
      end else begin
        trap_jump_addr = {mtvec_base, 2'b00};
      end
    end else if (exc_raise) begin
      new_mcause     = 32'(exc_code);
      trap_jump_addr = {mtvec_base, 2'b00};
    end
  end

endmodule

// File: tb/tb_trap_ctrl_v2.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl_v2
//
// Directed bench for trap_ctrl_v2. Two instances share every input: the
// main one with EXT_REDIRECT=1 and a second with EXT_REDIRECT=0, so the MEI
// cause redirect is visible side by side. Expected trap records are queued
// when the stimulus is driven and popped when trap_occurred shows up.
// ---------------------------------------------------------------------------
module tb_trap_ctrl_v2;

  localparam int PC_LEN = 32;
  localparam int NLI    = 8;
  localparam int ECW    = 5;
  localparam int IW     = 16 + NLI;

  logic              clk;
  logic              rst_sync;
  logic              flush;
  logic              stall_n;
  logic              exc_raise;
  logic [ECW-1:0]    exc_code;
  logic [PC_LEN-1:0] instr_addr_id_ex;
  logic [PC_LEN-1:0] jump_addr_ex;
  logic              jump_en_ex;
  logic              mstatus_mie;
  logic [IW-1:0]     mie;
  logic [IW-1:0]     mip;
  logic [29:0]       mtvec_base;
  logic [1:0]        mtvec_mode;
  logic [26:0]       ext_int_code;

  logic              any_interrupt_come, any_interrupt_come_0;
  logic              valid_interrupt_request, valid_interrupt_request_0;
  logic              trap_occurred, trap_occurred_0;
  logic              trap_busy, trap_busy_0;
  logic [PC_LEN-1:0] new_mepc, new_mepc_0;
  logic [31:0]       new_mcause, new_mcause_0;
  logic [31:0]       trap_jump_addr, trap_jump_addr_0;

  typedef struct {
    string       tag;
    logic [31:0] mcause;
    logic [31:0] mcause_alt;
    logic [31:0] target;
    logic [31:0] mepc;
  } exp_t;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  trap_ctrl_v2 #(
    .PC_LEN(PC_LEN), .NUM_LOCAL_INT(NLI), .EXC_CODE_W(ECW),
    .JUMP_HOLD(2), .EXT_REDIRECT(1)
  ) dut (
    .clk(clk), .rst_sync(rst_sync), .flush(flush), .stall_n(stall_n),
    .exc_raise(exc_raise), .exc_code(exc_code),
    .instr_addr_id_ex(instr_addr_id_ex), .jump_addr_ex(jump_addr_ex),
    .jump_en_ex(jump_en_ex), .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip),
    .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .ext_int_code(ext_int_code),
    .any_interrupt_come(any_interrupt_come),
    .valid_interrupt_request(valid_interrupt_request),
    .trap_occurred(trap_occurred), .trap_busy(trap_busy),
    .new_mepc(new_mepc), .new_mcause(new_mcause), .trap_jump_addr(trap_jump_addr)
  );

  trap_ctrl_v2 #(
    .PC_LEN(PC_LEN), .NUM_LOCAL_INT(NLI), .EXC_CODE_W(ECW),
    .JUMP_HOLD(2), .EXT_REDIRECT(0)
  ) dut0 (
    .clk(clk), .rst_sync(rst_sync), .flush(flush), .stall_n(stall_n),
    .exc_raise(exc_raise), .exc_code(exc_code),
    .instr_addr_id_ex(instr_addr_id_ex), .jump_addr_ex(jump_addr_ex),
    .jump_en_ex(jump_en_ex), .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip),
    .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .ext_int_code(ext_int_code),
    .any_interrupt_come(any_interrupt_come_0),
    .valid_interrupt_request(valid_interrupt_request_0),
    .trap_occurred(trap_occurred_0), .trap_busy(trap_busy_0),
    .new_mepc(new_mepc_0), .new_mcause(new_mcause_0), .trap_jump_addr(trap_jump_addr_0)
  );

  // Free-running clock, active edge is posedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1 ns past the next active edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive interrupt enables/pendings and the trap vector.
  task automatic applyStimulus(input logic [IW-1:0] en, input logic [IW-1:0] pd,
                               input logic [29:0] base, input logic [1:0] mode);
    mie        = en;
    mip        = pd;
    mtvec_base = base;
    mtvec_mode = mode;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] mc,
                         input logic [31:0] mc_alt, input logic [31:0] tgt,
                         input logic [31:0] pc);
    exp_t e;
    e.tag        = tag;
    e.mcause     = mc;
    e.mcause_alt = mc_alt;
    e.target     = tgt;
    e.mepc       = pc;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the commit pulse, then pop and compare one record.
  task automatic checkTrap(input int budget);
    exp_t e;
    int   waited;
    waited = 0;
    while (trap_occurred !== 1'b1 && waited < budget) begin
      nextCycle();
      waited++;
    end
    checkOutput("trap_seen", 32'(trap_occurred), 32'd1);
    checkOutput("trap_seen_alt", 32'(trap_occurred_0), 32'd1);
    checkOutput("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, "_mcause"}, new_mcause, e.mcause);
      checkOutput({e.tag, "_mcause_alt"}, new_mcause_0, e.mcause_alt);
      checkOutput({e.tag, "_target"}, trap_jump_addr, e.target);
      checkOutput({e.tag, "_target_alt"}, trap_jump_addr_0, e.target);
      checkOutput({e.tag, "_mepc"}, new_mepc, e.mepc);
      checkOutput({e.tag, "_mepc_alt"}, new_mepc_0, e.mepc);
    end
  endtask

  // Directed sequence.
  initial begin
    rst_sync         = 1'b1;
    flush            = 1'b0;
    stall_n          = 1'b1;
    exc_raise        = 1'b0;
    exc_code         = '0;
    instr_addr_id_ex = 32'h0000_1234;
    jump_addr_ex     = '0;
    jump_en_ex       = 1'b0;
    mstatus_mie      = 1'b0;
    ext_int_code     = '0;
    applyStimulus('0, '0, '0, 2'b00);

    nextCycle();
    nextCycle();
    rst_sync = 1'b0;
    #1;
    checkOutput("idle_any", 32'(any_interrupt_come), 32'd0);
    checkOutput("idle_valid", 32'(valid_interrupt_request), 32'd0);
    checkOutput("idle_trap", 32'(trap_occurred), 32'd0);
    checkOutput("idle_busy", 32'(trap_busy), 32'd0);
    checkOutput("idle_busy_alt", 32'(trap_busy_0), 32'd0);
    checkOutput("idle_mcause", new_mcause, 32'd0);
    checkOutput("idle_target", trap_jump_addr, 32'd0);
    checkOutput("idle_mepc", new_mepc, 32'h0000_1234);

    // MTI, vectored mtvec 0x0000_1001
    mstatus_mie = 1'b1;
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    #1;
    checkOutput("mti_any", 32'(any_interrupt_come), 32'd1);
    checkOutput("mti_valid", 32'(valid_interrupt_request), 32'd1);
    checkOutput("mti_valid_alt", 32'(valid_interrupt_request_0), 32'd1);
    pushExp("mti", 32'h8000_0007, 32'h8000_0007, 32'h0000_101C, 32'h0000_1234);
    nextCycle();
    checkOutput("mti_armed_busy", 32'(trap_busy), 32'd1);
    checkOutput("mti_armed_trap", 32'(trap_occurred), 32'd0);
    checkOutput("mti_armed_valid", 32'(valid_interrupt_request), 32'd0);
    checkTrap(4);
    applyStimulus('0, '0, 30'h400, 2'b01);
    nextCycle();
    checkOutput("mti_after_trap", 32'(trap_occurred), 32'd0);
    checkOutput("mti_after_busy", 32'(trap_busy), 32'd0);

    // MEI + MSI + local16, direct mode, external code 5
    ext_int_code = 27'd5;
    applyStimulus(IW'(24'h01_0808), IW'(24'h01_0808), 30'h400, 2'b00);
    pushExp("mei", 32'h8000_0050, 32'h8000_000B, 32'h0000_1000, 32'h0000_1234);
    checkTrap(4);
    applyStimulus('0, '0, 30'h400, 2'b00);
    nextCycle();

    // MSI beats MTI, vectored
    applyStimulus(IW'(24'h88), IW'(24'h88), 30'h400, 2'b01);
    pushExp("msi", 32'h8000_0003, 32'h8000_0003, 32'h0000_100C, 32'h0000_1234);
    checkTrap(4);
    applyStimulus('0, '0, 30'h400, 2'b01);
    nextCycle();

    // local 17 beats local 20; MSI pending but not enabled is ignored
    applyStimulus(IW'(24'h12_0000), IW'(24'h12_0008), 30'h400, 2'b01);
    pushExp("local17", 32'h8000_0011, 32'h8000_0011, 32'h0000_1044, 32'h0000_1234);
    checkTrap(4);
    applyStimulus('0, '0, 30'h400, 2'b01);
    nextCycle();

    // exception while ARMED: exception wins, interrupt re-evaluated after
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    nextCycle();
    checkOutput("exc_armed_busy", 32'(trap_busy), 32'd1);
    exc_raise = 1'b1;
    exc_code  = 5'd2;
    pushExp("exc", 32'h0000_0002, 32'h0000_0002, 32'h0000_1000, 32'h0000_1234);
    #1;
    checkTrap(0);
    nextCycle();
    exc_raise = 1'b0;
    #1;
    checkOutput("exc_back_idle", 32'(trap_busy), 32'd0);
    checkOutput("exc_no_int_trap", 32'(trap_occurred), 32'd0);
    checkOutput("exc_reeval_valid", 32'(valid_interrupt_request), 32'd1);
    applyStimulus('0, '0, 30'h400, 2'b01);
    nextCycle();

    // flush blocks a new arm
    flush = 1'b1;
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    nextCycle();
    checkOutput("flush_no_arm", 32'(trap_busy), 32'd0);
    flush = 1'b0;
    applyStimulus('0, '0, 30'h400, 2'b01);
    nextCycle();

    // pending drops while ARMED
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    nextCycle();
    checkOutput("drop_armed_busy", 32'(trap_busy), 32'd1);
    applyStimulus(IW'(24'h80), '0, 30'h400, 2'b01);
    nextCycle();
    checkOutput("drop_no_trap", 32'(trap_occurred), 32'd0);
    checkOutput("drop_idle", 32'(trap_busy), 32'd0);
    applyStimulus('0, '0, 30'h400, 2'b01);

    // global enable drops while ARMED
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    nextCycle();
    mstatus_mie = 1'b0;
    nextCycle();
    checkOutput("mie_drop_no_trap", 32'(trap_occurred), 32'd0);
    checkOutput("mie_drop_idle", 32'(trap_busy), 32'd0);
    applyStimulus('0, '0, 30'h400, 2'b01);
    mstatus_mie = 1'b1;

    // reset in ARMED
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    nextCycle();
    checkOutput("rst_armed_busy", 32'(trap_busy), 32'd1);
    rst_sync = 1'b1;
    #1;
    checkOutput("rst_mask_busy", 32'(trap_busy), 32'd0);
    checkOutput("rst_mask_trap", 32'(trap_occurred), 32'd0);
    nextCycle();
    rst_sync = 1'b0;
    applyStimulus('0, '0, 30'h400, 2'b01);
    #1;
    checkOutput("rst_idle_busy", 32'(trap_busy), 32'd0);
    nextCycle();
    checkOutput("rst_idle_trap", 32'(trap_occurred), 32'd0);

    // jump tracking with a stall in the window
    jump_addr_ex = 32'h0000_0200;
    jump_en_ex   = 1'b1;
    #1;
    checkOutput("jmp_pre", new_mepc, 32'h0000_1234);
    nextCycle();
    jump_en_ex = 1'b0;
    #1;
    checkOutput("jmp_c1", new_mepc, 32'h0000_0200);
    nextCycle();
    checkOutput("jmp_c2", new_mepc, 32'h0000_0200);
    stall_n = 1'b0;
    nextCycle();
    checkOutput("jmp_stall_hold", new_mepc, 32'h0000_0200);
    stall_n = 1'b1;
    nextCycle();
    checkOutput("jmp_c3", new_mepc, 32'h0000_1234);

    // jump and exception together: pre-update mepc, clear wins over load
    applyStimulus(IW'(24'h80), IW'(24'h80), 30'h400, 2'b01);
    jump_addr_ex = 32'h0000_0300;
    jump_en_ex   = 1'b1;
    exc_raise    = 1'b1;
    exc_code     = 5'd4;
    pushExp("exc_jmp", 32'h0000_0004, 32'h0000_0004, 32'h0000_1000, 32'h0000_1234);
    #1;
    checkOutput("exc_blocks_valid", 32'(valid_interrupt_request), 32'd0);
    checkTrap(0);
    nextCycle();
    jump_en_ex = 1'b0;
    exc_raise  = 1'b0;
    applyStimulus('0, '0, 30'h400, 2'b01);
    #1;
    checkOutput("exc_jmp_no_arm", 32'(trap_busy), 32'd0);
    checkOutput("exc_jmp_clear", new_mepc, 32'h0000_1234);
    checkOutput("exc_jmp_mcause_idle", new_mcause, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
